spi_flash_seq: RTL and testbench
================================

# spi_flash_seq

Command sequencer for the memory-mapped SPI master peripheral. It accepts a flash read command (24-bit address, byte count) and issues the register-access sequence on the peripheral's request bus to perform a standard 0x03 READ. The sequence is: CS assert, opcode, three address bytes, N dummy-TX data bytes, CS release. Received bytes are delivered on a valid/ready byte stream. The block sits between the boot/DMA logic and the SPI master, which it drives as the master's only bus requester.

## Interface
Parameters:
- SPI_BASE, 32'h0000_0000: base address of the SPI master; register offsets are CTRL +0x00, STATUS +0x04, TXDATA +0x08, RXDATA +0x0C.
- CLK_DIV, 3'd2: value written to CTRL[3:1]. Must be nonzero; the master clamps 0 to 2.
- POLL_TIMEOUT, 16'd4096: maximum STATUS polls per byte before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  24  flash start address
- cmd_len  in  8  bytes to read; 0 means 256
- rd_valid  out  1  received data byte valid
- rd_ready  in  1  consumer accepts byte
- rd_data  out  8  received byte
- rd_last  out  1  high with final byte of command
- done  out  1  one-cycle pulse at command completion
- err  out  1  valid with done; 1 = poll timeout abort
- busy  out  1  high from command accept until done
- req_valid  out  1  SPI master access strobe, one cycle per access
- req_write  out  1  1 = write
- req_addr  out  32  SPI_BASE + offset
- req_wdata  out  32  write data
- req_wstrb  out  4  4'hF on writes, 4'h0 on reads
- rdata  in  32  SPI master read data, combinational and same-cycle with req

## Operation
- States: IDLE, CS_ON, TX_WR, POLL, RX_RD, OUT, CS_OFF, FIN.
- IDLE:
  - cmd_valid && cmd_ready latches the address, the 9-bit count (cmd_len==0 → 256) and the byte index 0, then goes to CS_ON.
- CS_ON:
  - Writes CTRL = 32'h100 | CLK_DIV<<1 | 1. This sets cs_force and enable.
  - Next state is TX_WR.
- TX_WR:
  - Writes TXDATA. Index 0 sends 8'h03. Indices 1–3 send addr[23:16], addr[15:8], addr[7:0]. Indices 4 and above send 8'h00.
  - Clears the poll counter, then goes to POLL.
- POLL:
  - Reads STATUS every cycle.
  - If rdata[1]==1 (rx_valid) && rdata[0]==0 (busy), go to RX_RD.
  - Otherwise increment the poll counter. At POLL_TIMEOUT, set the err flag and go to CS_OFF.
- RX_RD:
  - Reads RXDATA and captures rdata[7:0] in the same cycle.
  - Header bytes (index 0–3) are discarded.
  - Data bytes go to OUT.
  - Then increment the index. If more bytes remain, go to TX_WR; otherwise go to CS_OFF.
- OUT:
  - Holds rd_valid with rd_data stable until rd_ready. No SPI access is issued while waiting.
  - rd_last = (final data byte).
  - On the handshake, go to TX_WR or CS_OFF.
- CS_OFF:
  - Writes CTRL = CLK_DIV<<1 | 1. This releases CS and keeps the master enabled.
  - Next state is FIN.
- FIN:
  - Pulses done, with err = the error flag. Clears the flag and returns to IDLE.
- Exactly one SPI access per cycle at most. req_valid is never high in IDLE, OUT or FIN.
- Total TX bytes per command = 4 + count. The index is 9+ bits wide (max 260).
- The address is not wrapped or checked by this block; flash wrap is the device's behaviour.

## Timing
- Reset (rst_n low at a clk edge), all outputs:
  - state = IDLE
  - cmd_ready=0 during the reset cycle, 1 after
  - rd_valid=0, rd_last=0, rd_data=0
  - done=0, err=0, busy=0
  - req_valid=0, req_write=0, req_addr=SPI_BASE, req_wdata=0, req_wstrb=0
- Reset mid-command:
  - Abandons the command immediately and issues no CS release.
  - The system resets the SPI master together with this block.
- Command accept → first CTRL write: 1 cycle. cmd_ready drops the cycle after accept.
- POLL begins the cycle after the TXDATA write, when the master's busy is already 1. A stale rx_valid from the previous byte is therefore never accepted.
- Per-byte overhead beyond SPI shift time: TX_WR 1 + RX_RD 1 + at least 1 poll cycle.
- rd_valid asserts the cycle after RX_RD and may stay high indefinitely. There is no timeout in OUT.
- done fires exactly once per accepted command, one cycle after the CS_OFF write. busy falls in the same cycle as done.
- cmd_valid asserted while busy is ignored. It is not queued.

## Test plan
- Read addr 24'h012345, len 4, SPI slave model returning 8'hA0..A3:
  - Bus shows CTRL 0x105, TXDATA 03, 01, 23, 45, 00×4, then CTRL 0x005.
  - Stream is A0, A1, A2, A3 with rd_last only on A3.
  - done=1, err=0.
- len 0:
  - Exactly 256 bytes are streamed and 260 TXDATA writes are issued.
  - rd_last on byte 256; one done pulse.
- Backpressure: rd_ready held low for 50 cycles on byte 2.
  - rd_data stable and rd_valid high throughout.
  - No req_valid during the stall.
  - Stream is correct after release.
- Timeout: slave model forces STATUS busy=1 forever (POLL_TIMEOUT=16).
  - After 16 polls, CTRL write 0x005, then done=1, err=1.
  - No rd_valid is produced.
- rst_n low during the third data byte's POLL:
  - Next cycle all outputs are at reset values and cmd_ready=1.
  - A new command after reset completes correctly.
- cmd_valid held high across completion:
  - The second command is accepted only in the cycle after done, when cmd_ready=1.

Source files
------------

// File: rtl/spi_flash_seq.sv
// rtl/spi_flash_seq.sv - 0x03 READ command sequencer driving the SPI master register bus
module spi_flash_seq #(
    parameter logic [31:0] SPI_BASE     = 32'h0000_0000,
    parameter logic [2:0]  CLK_DIV      = 3'd2,
    parameter logic [15:0] POLL_TIMEOUT = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        req_valid,
    output logic        req_write,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic [31:0] rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CS_ON  = 3'd1;
    localparam logic [2:0] S_TX_WR  = 3'd2;
    localparam logic [2:0] S_POLL   = 3'd3;
    localparam logic [2:0] S_RX_RD  = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;
    localparam logic [2:0] S_CS_OFF = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_TXDATA = 32'h0000_0008;
    localparam logic [31:0] OFF_RXDATA = 32'h0000_000C;

    // CTRL: bit 8 cs_force, bits 3:1 clock divider, bit 0 enable
    localparam logic [31:0] CTRL_CS_ON  = {23'd0, 1'b1, 4'd0, CLK_DIV, 1'b1};
    localparam logic [31:0] CTRL_CS_OFF = {23'd0, 1'b0, 4'd0, CLK_DIV, 1'b1};

    localparam logic [15:0] POLL_LAST = POLL_TIMEOUT - 16'd1;

    logic [2:0]  state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  idx_q, idx_d;      // index of the byte on the wire, header included
    logic [8:0]  fin_idx_q, fin_idx_d;  // 4 + data byte count
    logic [15:0] poll_q, poll_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  tx_byte;
    logic        rx_ok;
    logic        rdata_unused;

    assign rdata_unused = ^rdata[31:8];
    assign rx_ok        = rdata[1] && !rdata[0];

    // Byte to shift out for the current index: opcode, address MSB first, then dummy bytes
    always_comb begin
        tx_byte = 8'h00;
        case (idx_q)
            9'd0:    tx_byte = 8'h03;
            9'd1:    tx_byte = addr_q[23:16];
            9'd2:    tx_byte = addr_q[15:8];
            9'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    // Next-state and datapath updates of the sequencer
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        fin_idx_d = fin_idx_q;
        poll_d    = poll_q;
        err_d     = err_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    idx_d     = 9'd0;
                    fin_idx_d = (cmd_len == 8'd0) ? 9'd260 : ({1'b0, cmd_len} + 9'd4);
                    err_d     = 1'b0;
                    state_d   = S_CS_ON;
                end
            end
            S_CS_ON: state_d = S_TX_WR;
            S_TX_WR: begin
                poll_d  = 16'd0;
                state_d = S_POLL;
            end
            S_POLL: begin
                if (rx_ok) begin
                    state_d = S_RX_RD;
                end else if (poll_q == POLL_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_CS_OFF;
                end else begin
                    poll_d = poll_q + 16'd1;
                end
            end
            S_RX_RD: begin
                idx_d = idx_q + 9'd1;
                if (idx_q < 9'd4) begin
                    // header echo bytes carry no flash data; at least one data byte always follows
                    state_d = S_TX_WR;
                end else begin
                    data_d  = rdata[7:0];
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (rd_ready) begin
                    state_d = (idx_q == fin_idx_q) ? S_CS_OFF : S_TX_WR;
                end
            end
            S_CS_OFF: state_d = S_FIN;
            S_FIN: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register stage with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= 24'd0;
            idx_q     <= 9'd0;
            fin_idx_q <= 9'd0;
            poll_q    <= 16'd0;
            err_q     <= 1'b0;
            data_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            fin_idx_q <= fin_idx_d;
            poll_q    <= poll_d;
            err_q     <= err_d;
            data_q    <= data_d;
        end
    end

    // Register-bus access issued in the current state, at most one per cycle
    always_comb begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = SPI_BASE;
        req_wdata = 32'd0;
        req_wstrb = 4'h0;
        case (state_q)
            S_CS_ON: begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = SPI_BASE + OFF_CTRL;
                req_wdata = CTRL_CS_ON;
                req_wstrb = 4'hF;
            end
            S_TX_WR: begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = SPI_BASE + OFF_TXDATA;
                req_wdata = {24'd0, tx_byte};
                req_wstrb = 4'hF;
            end
            S_POLL: begin
                req_valid = 1'b1;
                req_addr  = SPI_BASE + OFF_STATUS;
            end
            S_RX_RD: begin
                req_valid = 1'b1;
                req_addr  = SPI_BASE + OFF_RXDATA;
            end
            S_CS_OFF: begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = SPI_BASE + OFF_CTRL;
                req_wdata = CTRL_CS_OFF;
                req_wstrb = 4'hF;
            end
            default: ;
        endcase
    end

    // cmd_ready is held low while reset is asserted so nothing is accepted in that cycle
    assign cmd_ready = rst_n && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign rd_valid  = (state_q == S_OUT);
    assign rd_last   = rd_valid && (idx_q == fin_idx_q);
    assign rd_data   = data_q;
    assign done      = (state_q == S_FIN);
    assign err       = done && err_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// tb/tb_spi_flash_seq.sv - scoreboard bench for spi_flash_seq with an SPI master register model
module tb_spi_flash_seq;

    localparam logic [31:0] BASE  = 32'h4000_1000;
    localparam int          SHIFT = 3;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic        rd_last;
    logic        done;
    logic        err;
    logic        busy;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] rdata;

    spi_flash_seq #(
        .SPI_BASE(BASE),
        .CLK_DIV(3'd2),
        .POLL_TIMEOUT(16'd16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err), .busy(busy),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [95:0] exp_bus[$];
    logic [95:0] exp_rd[$];
    logic [95:0] exp_done[$];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // SPI master register model: TXDATA starts a SHIFT-cycle transfer, RXDATA read clears rx_valid
    int          busy_cnt;
    int          tx_cnt;
    logic        rx_valid_s;
    logic [7:0]  rx_byte_s;
    logic        force_busy;
    logic [7:0]  slave_base;
    logic        s_v, s_w;
    logic [31:0] s_a, s_d;

    assign rdata = (req_addr == BASE + 32'd4)  ? {30'd0, rx_valid_s, (busy_cnt != 0) || force_busy} :
                   (req_addr == BASE + 32'd12) ? {24'd0, rx_byte_s} : 32'd0;

    always @(negedge clk) begin
        s_v <= req_valid;
        s_w <= req_write;
        s_a <= req_addr;
        s_d <= req_wdata;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt   <= 0;
            tx_cnt     <= 0;
            rx_valid_s <= 1'b0;
            rx_byte_s  <= 8'd0;
        end else begin
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) rx_valid_s <= 1'b1;
            end
            if (s_v && s_w && s_a == BASE + 32'd8) begin
                busy_cnt   <= SHIFT;
                rx_valid_s <= 1'b0;
                rx_byte_s  <= (tx_cnt < 4) ? 8'hFF : slave_base + 8'(tx_cnt - 4);
                tx_cnt     <= tx_cnt + 1;
            end
            if (s_v && s_w && s_a == BASE && s_d[8]) tx_cnt <= 0;
            if (s_v && !s_w && s_a == BASE + 32'd12) rx_valid_s <= 1'b0;
        end
    end

    // Output monitor: pops the scoreboard on bus writes, stream handshakes and done pulses
    int acc_cnt = 0, rdv_cnt = 0, txw_cnt = 0, rdb_cnt = 0, done_cnt = 0;
    int polls = 0, last_polls = 0, bad_req = 0;
    always @(negedge clk) begin
        logic [95:0] e;
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (rd_valid) rdv_cnt++;
        if (req_valid && (rd_valid || done || cmd_ready)) bad_req++;
        if (req_valid && req_write) begin
            e = (exp_bus.size() > 0) ? exp_bus.pop_front() : 96'd0;
            chk("bus_write", {27'd0, req_write, req_addr, req_wdata, req_wstrb}, e);
            if (req_addr == BASE + 32'd8) txw_cnt++;
            last_polls = polls;
            polls = 0;
        end
        if (req_valid && !req_write && req_addr == BASE + 32'd4) polls++;
        if (rd_valid && rd_ready) begin
            e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 96'd0;
            chk("rd_byte", {86'd0, 1'b1, rd_last, rd_data}, e);
            rdb_cnt++;
        end
        if (done) begin
            e = (exp_done.size() > 0) ? exp_done.pop_front() : 96'd0;
            chk("done_err", {94'd0, 1'b1, err}, e);
            done_cnt++;
        end
    end

    function automatic logic [95:0] bw(input logic [31:0] off, input logic [31:0] d);
        return {27'd0, 1'b1, BASE + off, d, 4'hF};
    endfunction

    task automatic push_cmd(input logic [23:0] a, input logic [7:0] len,
                            input logic [7:0] b, input logic tmo);
        int n;
        n = (len == 8'd0) ? 256 : int'(len);
        exp_bus.push_back(bw(32'h0, 32'h105));
        exp_bus.push_back(bw(32'h8, 32'h03));
        if (!tmo) begin
            exp_bus.push_back(bw(32'h8, {24'd0, a[23:16]}));
            exp_bus.push_back(bw(32'h8, {24'd0, a[15:8]}));
            exp_bus.push_back(bw(32'h8, {24'd0, a[7:0]}));
            for (int j = 0; j < n; j++) begin
                exp_bus.push_back(bw(32'h8, 32'h0));
                exp_rd.push_back({86'd0, 1'b1, (j == n - 1), b + 8'(j)});
            end
        end
        exp_bus.push_back(bw(32'h0, 32'h005));
        exp_done.push_back({94'd0, 1'b1, tmo});
    endtask

    task automatic start_cmd(input logic [23:0] a, input logic [7:0] len);
        logic got = 1'b0;
        @(posedge clk); #1;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        chk("cmd_accept", 96'(got), 96'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("accept_ready_busy", 96'({cmd_ready, busy}), 96'(2'b01));
        chk("first_ctrl_latency", 96'({req_valid, req_write, req_addr}), 96'({2'b11, BASE}));
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        chk(tag, 96'(got), 96'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 96'({cmd_ready, rd_valid, rd_last, rd_data, done, err, busy}),
            96'({1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}));
        chk({tag, "_bus"}, {27'd0, req_valid, req_write, req_addr, req_wdata, req_wstrb},
            {27'd0, 1'b0, 1'b0, BASE, 32'd0, 4'h0});
    endtask

    initial begin
        logic        got;
        logic [7:0]  cap;
        int          unstable, stall_req;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = 24'd0;
        cmd_len    = 8'd0;
        rd_ready   = 1'b1;
        force_busy = 1'b0;
        slave_base = 8'hA0;

        // Reset state
        @(negedge clk);
        chk("reset_cycle_cmd_ready", 96'(cmd_ready), 96'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Basic 4-byte read
        push_cmd(24'h012345, 8'd4, 8'hA0, 1'b0);
        start_cmd(24'h012345, 8'd4);
        wait_done("done_basic", 500);

        // len 0 means 256 bytes
        @(posedge clk); #1;
        txw_cnt = 0; rdb_cnt = 0; done_cnt = 0;
        slave_base = 8'h00;
        push_cmd(24'hFFFFFE, 8'd0, 8'h00, 1'b0);
        start_cmd(24'hFFFFFE, 8'd0);
        wait_done("done_len0", 6000);
        @(posedge clk); #1;
        chk("len0_txdata_writes", 96'(txw_cnt), 96'(260));
        chk("len0_bytes", 96'(rdb_cnt), 96'(256));
        chk("len0_done_count", 96'(done_cnt), 96'(1));

        // Backpressure on the second data byte
        slave_base = 8'h30;
        rd_ready   = 1'b0;
        push_cmd(24'h000100, 8'd4, 8'h30, 1'b0);
        start_cmd(24'h000100, 8'd4);
        for (int j = 0; j < 4; j++) begin
            got = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (rd_valid) begin got = 1'b1; break; end
            end
            chk("bp_rd_valid_seen", 96'(got), 96'(1));
            if (j == 1) begin
                cap = rd_data;
                unstable = 0;
                stall_req = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (!rd_valid || rd_data !== cap) unstable++;
                    if (req_valid) stall_req++;
                end
                chk("bp_stable", 96'(unstable), 96'(0));
                chk("bp_no_req", 96'(stall_req), 96'(0));
            end
            @(posedge clk); #1;
            rd_ready = 1'b1;
            @(posedge clk); #1;
            rd_ready = 1'b0;
        end
        rd_ready = 1'b1;
        wait_done("done_bp", 500);

        // Poll timeout
        @(posedge clk); #1;
        force_busy = 1'b1;
        rdv_cnt = 0;
        push_cmd(24'h000000, 8'd4, 8'h00, 1'b1);
        start_cmd(24'h000000, 8'd4);
        wait_done("done_timeout", 500);
        @(posedge clk); #1;
        chk("timeout_polls", 96'(last_polls), 96'(16));
        chk("timeout_no_rd_valid", 96'(rdv_cnt), 96'(0));
        force_busy = 1'b0;

        // Reset during the third data byte's poll
        slave_base = 8'h50;
        push_cmd(24'h00ABCD, 8'd8, 8'h50, 1'b0);
        start_cmd(24'h00ABCD, 8'd8);
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_cnt == 7 && busy_cnt == SHIFT && req_valid && !req_write && req_addr == BASE + 32'd4) begin
                got = 1'b1;
                break;
            end
        end
        chk("mid_reset_reach_poll", 96'(got), 96'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_bus.delete();
        exp_rd.delete();
        exp_done.delete();
        @(negedge clk);
        chk("mid_reset_cmd_ready_low", 96'(cmd_ready), 96'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        slave_base = 8'h60;
        push_cmd(24'h000010, 8'd3, 8'h60, 1'b0);
        start_cmd(24'h000010, 8'd3);
        wait_done("done_after_reset", 500);

        // cmd_valid held high across completion
        @(posedge clk); #1;
        slave_base = 8'h70;
        acc_cnt = 0;
        push_cmd(24'h123456, 8'd2, 8'h70, 1'b0);
        push_cmd(24'h123456, 8'd2, 8'h70, 1'b0);
        cmd_addr  = 24'h123456;
        cmd_len   = 8'd2;
        cmd_valid = 1'b1;
        wait_done("done_hold_first", 500);
        chk("hold_ready_at_done", 96'(cmd_ready), 96'(0));
        chk("hold_single_accept", 96'(acc_cnt), 96'(1));
        @(negedge clk);
        chk("hold_ready_after_done", 96'(cmd_ready), 96'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done("done_hold_second", 500);
        @(posedge clk); #1;
        chk("hold_accept_count", 96'(acc_cnt), 96'(2));

        // Drain checks
        repeat (3) @(negedge clk);
        chk("bus_queue_empty", 96'(exp_bus.size()), 96'(0));
        chk("rd_queue_empty", 96'(exp_rd.size()), 96'(0));
        chk("done_queue_empty", 96'(exp_done.size()), 96'(0));
        chk("no_req_in_idle_out_fin", 96'(bad_req), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
